encoder_serial_ntolog: RTL and testbench

//  Encoder counterpart of the demux-based one-hot decoder. Accepts an N-bit request vector
//  and emits the binary index of every set bit, one index per output handshake, in priority

---
 rtl/encoder_serial_ntolog_if.sv | 38 +++
 rtl/encoder_serial_ntolog.sv | 105 ++++++++++
 tb/tb_encoder_serial_ntolog.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/encoder_serial_ntolog_if.sv
// Handshake bundle for encoder_serial_ntolog: request vector in, index beats out.
// master is the surrounding logic, slave is the encoder itself.
interface encoder_serial_ntolog_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [W-1:0] out_seq;
    logic         out_last;

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_seq,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_seq,
        output out_last
    );
endinterface

// File: rtl/encoder_serial_ntolog.sv
// Serialises an N-bit request vector into a stream of set-bit indices.
// Define ENC_MSB_FIRST_EN to scan highest index first (default: lowest first).
module encoder_serial_ntolog #(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    encoder_serial_ntolog_if.slave   bus,
    output logic                     busy,
    output logic                     drop_pulse
);
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pending;
    logic [N-1:0] pending_nxt;
    logic [W-1:0] seq;
    logic [W-1:0] seq_nxt;
    logic [W-1:0] idx;
    logic         one_left;
    logic         drop_nxt;

    // Later loop iterations win, so the loop order sets the priority.
    always_comb begin
        idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (pending[i]) idx = W'(i);
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) idx = W'(i);
        end
`endif
    end

    assign one_left = (pending != '0) &&
                      ((pending & (pending - N'(1))) == '0);

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        seq_nxt       = seq;
        drop_nxt      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_idx   = '0;
        bus.out_seq   = '0;
        bus.out_last  = 1'b0;
        busy          = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    bus.in_ready = 1'b1;
                    if (bus.in_valid) begin
                        if (bus.in_vec != '0) begin
                            pending_nxt = bus.in_vec;
                            seq_nxt     = '0;
                            state_nxt   = EMIT;
                        end else begin
                            drop_nxt = 1'b1;
                        end
                    end
                end
                EMIT: begin
                    bus.out_valid = 1'b1;
                    busy          = 1'b1;
                    bus.out_idx   = idx;
                    bus.out_seq   = seq;
                    bus.out_last  = one_left;
                    if (bus.out_ready) begin
                        pending_nxt = pending & ~(N'(1) << idx);
                        if (one_left) begin
                            seq_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            seq_nxt = seq + W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            seq        <= '0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            seq        <= seq_nxt;
            drop_pulse <= drop_nxt;
        end
    end
endmodule

// File: tb/tb_encoder_serial_ntolog.sv
// Directed bench for encoder_serial_ntolog (N=4 and N=8 instances).
// Expected index order follows ENC_MSB_FIRST_EN when it is defined.
module tb_encoder_serial_ntolog;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy4;
    logic drop4;
    logic busy8;
    logic drop8;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    encoder_serial_ntolog_if #(.N(4)) b4 ();
    encoder_serial_ntolog_if #(.N(8)) b8 ();

    encoder_serial_ntolog #(.N(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b4.slave),
        .busy      (busy4),
        .drop_pulse(drop4)
    );

    encoder_serial_ntolog #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b8.slave),
        .busy      (busy8),
        .drop_pulse(drop8)
    );

`ifdef ENC_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b4.in_valid = 1'b0;
        b4.in_vec = '0;
        b4.out_ready = 1'b0;
        b8.in_valid = 1'b0;
        b8.in_vec = '0;
        b8.out_ready = 1'b0;
        step();
        step();
        chk("rst in_ready", int'(b4.in_ready), 0);
        chk("rst out_valid", int'(b4.out_valid), 0);
        chk("rst busy", int'(busy4), 0);
        chk("rst drop", int'(drop4), 0);
        chk("rst8 in_ready", int'(b8.in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", int'(b4.in_ready), 1);
        chk("post-rst8 in_ready", int'(b8.in_ready), 1);
    endtask

    task automatic test_order();
        int e0 = MSB ? 3 : 1;
        int e1 = MSB ? 1 : 3;
        b4.in_vec = 4'b1010;
        b4.in_valid = 1'b1;
        b4.out_ready = 1'b1;
        step();
        b4.in_valid = 1'b0;
        b4.in_vec = 4'b0000;
        chk("ord b0 valid", int'(b4.out_valid), 1);
        chk("ord b0 idx", int'(b4.out_idx), e0);
        chk("ord b0 seq", int'(b4.out_seq), 0);
        chk("ord b0 last", int'(b4.out_last), 0);
        chk("ord b0 busy", int'(busy4), 1);
        chk("ord b0 in_ready", int'(b4.in_ready), 0);
        step();
        chk("ord b1 valid", int'(b4.out_valid), 1);
        chk("ord b1 idx", int'(b4.out_idx), e1);
        chk("ord b1 seq", int'(b4.out_seq), 1);
        chk("ord b1 last", int'(b4.out_last), 1);
        step();
        chk("ord done valid", int'(b4.out_valid), 0);
        chk("ord done in_ready", int'(b4.in_ready), 1);
    endtask

    task automatic test_stall();
        b4.in_vec = 4'b0100;
        b4.in_valid = 1'b1;
        b4.out_ready = 1'b0;
        step();
        b4.in_valid = 1'b0;
        b4.in_vec = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            chk("stall valid", int'(b4.out_valid), 1);
            chk("stall idx", int'(b4.out_idx), 2);
            chk("stall seq", int'(b4.out_seq), 0);
            chk("stall last", int'(b4.out_last), 1);
            step();
        end
        chk("stall held valid", int'(b4.out_valid), 1);
        b4.out_ready = 1'b1;
        step();
        chk("stall done valid", int'(b4.out_valid), 0);
        chk("stall done in_ready", int'(b4.in_ready), 1);
    endtask

    task automatic test_drop();
        chk("drop idle", int'(drop4), 0);
        b4.in_vec = 4'b0000;
        b4.in_valid = 1'b1;
        step();
        b4.in_valid = 1'b0;
        chk("drop pulse", int'(drop4), 1);
        chk("drop valid", int'(b4.out_valid), 0);
        chk("drop in_ready", int'(b4.in_ready), 1);
        step();
        chk("drop end", int'(drop4), 0);
        chk("drop end valid", int'(b4.out_valid), 0);
    endtask

    task automatic test_mid_reset();
        b4.in_vec = 4'b1111;
        b4.in_valid = 1'b1;
        b4.out_ready = 1'b1;
        step();
        b4.in_valid = 1'b0;
        chk("mr b0 idx", int'(b4.out_idx), MSB ? 3 : 0);
        chk("mr b0 last", int'(b4.out_last), 0);
        step();
        chk("mr b1 seq", int'(b4.out_seq), 1);
        rst = 1'b1;
        #1;
        chk("mr rst valid", int'(b4.out_valid), 0);
        chk("mr rst idx", int'(b4.out_idx), 0);
        chk("mr rst seq", int'(b4.out_seq), 0);
        chk("mr rst in_ready", int'(b4.in_ready), 0);
        step();
        rst = 1'b0;
        #1;
        chk("mr post valid", int'(b4.out_valid), 0);
        chk("mr post busy", int'(busy4), 0);
        chk("mr post in_ready", int'(b4.in_ready), 1);
        b4.in_vec = 4'b0001;
        b4.in_valid = 1'b1;
        step();
        b4.in_valid = 1'b0;
        chk("mr new valid", int'(b4.out_valid), 1);
        chk("mr new idx", int'(b4.out_idx), 0);
        chk("mr new seq", int'(b4.out_seq), 0);
        chk("mr new last", int'(b4.out_last), 1);
        step();
        chk("mr new done", int'(b4.out_valid), 0);
    endtask

    task automatic test_n8_full();
        b8.in_vec = 8'hFF;
        b8.in_valid = 1'b1;
        b8.out_ready = 1'b1;
        step();
        b8.in_valid = 1'b0;
        b8.in_vec = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("n8 valid", int'(b8.out_valid), 1);
            chk("n8 idx", int'(b8.out_idx), MSB ? 7 - i : i);
            chk("n8 seq", int'(b8.out_seq), i);
            chk("n8 last", int'(b8.out_last), (i == 7) ? 1 : 0);
            step();
        end
        chk("n8 done valid", int'(b8.out_valid), 0);
        chk("n8 done in_ready", int'(b8.in_ready), 1);
    endtask

    initial begin
        test_reset();
        test_order();
        test_stall();
        test_drop();
        test_mid_reset();
        test_n8_full();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
